// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with double-buffered duty/period registers that swap in on counter wrap.
// Optional shadow-register readback is built when PWM_BANK_READBACK_EN is defined.
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  localparam int ADDR_W  = $clog2(CHANNELS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  logic [WIDTH-1:0]                 cnt_reg;
  logic [WIDTH-1:0]                 period_sh_reg;
  logic [WIDTH-1:0]                 period_act_reg;
  logic                             period_tick_reg;
  logic [CHANNELS-1:0][WIDTH-1:0]   duty_sh_flat;
  logic                             wrap;

  assign wrap        = (cnt_reg == period_act_reg);
  assign period_tick = period_tick_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg         <= '0;
      period_sh_reg   <= '1;
      period_act_reg  <= '1;
      period_tick_reg <= 1'b0;
    end else begin
      if (wr_en && wr_addr == ADDR_W'(CHANNELS))
        period_sh_reg <= wr_data;
      // The active period loads the pre-edge shadow, so a write on the wrap edge waits a period.
      if (wrap) begin
        cnt_reg         <= '0;
        period_act_reg  <= period_sh_reg;
        period_tick_reg <= 1'b1;
      end else begin
        cnt_reg         <= cnt_reg + WIDTH'(1);
        period_tick_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_sh_reg;
    logic [WIDTH-1:0] duty_act_reg;
    logic             pwm_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        duty_sh_reg  <= '0;
        duty_act_reg <= '0;
        pwm_reg      <= 1'b0;
      end else begin
        if (wr_en && wr_addr == ADDR_W'(gi))
          duty_sh_reg <= wr_data;
        if (wrap)
          duty_act_reg <= duty_sh_reg;
        pwm_reg <= (cnt_reg < duty_act_reg);
      end
    end

    assign duty_sh_flat[gi] = duty_sh_reg;
    assign pwm_out[gi]      = pwm_reg;
  end

`ifdef PWM_BANK_READBACK_EN
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rd_data_reg;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (rd_addr == ADDR_W'(i))
        rd_mux = duty_sh_flat[i];
    if (rd_addr == ADDR_W'(CHANNELS))
      rd_mux = period_sh_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rd_data_reg <= '0;
    else
      rd_data_reg <= rd_mux;
  end

  assign rd_data = rd_data_reg;
`else
  logic rd_unused;
  logic [WIDTH-1:0] duty_sh_unused;

  assign rd_unused      = ^rd_addr;
  assign duty_sh_unused = duty_sh_flat[0];
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed tables, wrap-edge sequences and a randomized
// run compared against a behavioural model of the register/period rules.
module tb_pwm_bank;
  localparam int CH = 8;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [3:0]    rd_addr;
  logic [W-1:0]  rd_data;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: position within the current period plus shadow/active tables.
  int          m_pos, m_per, m_per_sh;
  int          m_dsh [CH];
  int          m_dact[CH];
  logic [CH-1:0] m_pwm;
  logic        m_tick;
  int          m_rd;

  int hi[4];
  int n_tick, tick_bad, first_hi;

  typedef struct {
    int per;
    int duty;
    int exp_hi;
  } vec_t;
  vec_t vecs[9];

  task automatic model_step();
    int ra, wa;
    if (!rst) begin
      m_pos = 0; m_per = 65535; m_per_sh = 65535;
      for (int i = 0; i < CH; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
      m_pwm = '0; m_tick = 1'b0; m_rd = 0;
      return;
    end
    ra = int'(rd_addr);
`ifdef PWM_BANK_READBACK_EN
    m_rd = (ra < CH) ? m_dsh[ra] : (ra == CH) ? m_per_sh : 0;
`else
    m_rd = 0;
`endif
    for (int i = 0; i < CH; i++) m_pwm[i] = (m_pos < m_dact[i]);
    if (m_pos == m_per) begin
      m_pos = 0;
      for (int i = 0; i < CH; i++) m_dact[i] = m_dsh[i];
      m_per = m_per_sh;
      m_tick = 1'b1;
    end else begin
      m_pos = m_pos + 1;
      m_tick = 1'b0;
    end
    if (wr_en) begin
      wa = int'(wr_addr);
      if (wa < CH) m_dsh[wa] = int'(wr_data);
      else if (wa == CH) m_per_sh = int'(wr_data);
    end
  endtask

  // One clock: model advances on the edge, DUT is observed at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pwm"}, longint'(pwm_out), longint'(m_pwm));
    check({tag, "_tick"}, longint'(period_tick), longint'(m_tick));
    check({tag, "_rd"}, longint'(rd_data), longint'(m_rd));
  endtask

  task automatic write(input logic [3:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!period_tick && n < 100);
    if (!period_tick) check("wait_tick_timeout", 0, 1);
  endtask

  // Observe nper periods of length P+1 starting at cnt=0; optionally write ch0 before sample wr_k.
  task automatic window(input int P, input int nper, input int wr_k, input logic [W-1:0] wd);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    n_tick = 0; tick_bad = 0; first_hi = 0;
    for (int k = 1; k <= nper * (P + 1); k++) begin
      if (k == wr_k) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = wd; end
      cyc();
      wr_en = 1'b0;
      if (pwm_out[0]) begin
        hi[(k - 1) / (P + 1)]++;
        if (first_hi == 0) first_hi = k;
      end
      if (period_tick) begin
        n_tick++;
        if (k % (P + 1) != 0) tick_bad++;
      end
    end
  endtask

  initial begin
    int k_tick;
    bit any_hi;
    logic [W-1:0] exp_rb;

    vecs[0] = '{9, 3, 3};
    vecs[1] = '{9, 0, 0};
    vecs[2] = '{9, 10, 10};
    vecs[3] = '{9, 16'hFFFF, 10};
    vecs[4] = '{0, 1, 1};
    vecs[5] = '{0, 0, 0};
    vecs[6] = '{4, 2, 2};
    vecs[7] = '{15, 16, 16};
    vecs[8] = '{15, 15, 15};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    cyc(); cyc();
    check("reset_pwm", longint'(pwm_out), 0);
    check("reset_tick", longint'(period_tick), 0);
    check("reset_rd", longint'(rd_data), 0);
    rst = 1'b1;

    // Default period is 2^16 cycles; shadows written early load at that first wrap.
    k_tick = 0; any_hi = 1'b0;
    for (int k = 1; k <= 66000; k++) begin
      if (k == 1) begin wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'd9; end
      else if (k == 2) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd3; end
      else wr_en = 1'b0;
      cyc();
      if (pwm_out != '0) any_hi = 1'b1;
      if (period_tick) begin k_tick = k; break; end
    end
    wr_en = 1'b0;
    check("first_tick_cycle", k_tick, 65536);
    check("idle_pwm_low", longint'(any_hi), 0);
    $display("first wrap: tick after %0d cycles", k_tick);

    for (int v = 0; v < 9; v++) begin
      write(4'd8, W'(vecs[v].per));
      write(4'd0, W'(vecs[v].duty));
      wait_tick();
      window(vecs[v].per, 2, 0, '0);
      $display("vec %0d: period=%0d duty=%0h high=%0d/%0d ticks=%0d", v, vecs[v].per,
               vecs[v].duty, hi[0], hi[1], n_tick);
      check($sformatf("vec%0d_hi0", v), hi[0], vecs[v].exp_hi);
      check($sformatf("vec%0d_hi1", v), hi[1], vecs[v].exp_hi);
      check($sformatf("vec%0d_first_hi", v), first_hi, (vecs[v].exp_hi > 0) ? 1 : 0);
      check($sformatf("vec%0d_ticks", v), n_tick, 2);
      check($sformatf("vec%0d_tick_pos", v), tick_bad, 0);
    end

    write(4'd8, 16'd9);
    write(4'd0, 16'd3);
    wait_tick();
    window(9, 2, 5, 16'd7);
    $display("mid-period change: high=%0d then %0d", hi[0], hi[1]);
    check("mid_change_p0", hi[0], 3);
    check("mid_change_p1", hi[1], 7);
    window(9, 3, 10, 16'd2);
    $display("wrap-edge change: high=%0d %0d %0d", hi[0], hi[1], hi[2]);
    check("wrap_write_p0", hi[0], 7);
    check("wrap_write_p1", hi[1], 7);
    check("wrap_write_p2", hi[2], 2);

    write(4'd9, 16'h1234);
    window(9, 1, 0, '0);
    check("oor_pwm_hi", hi[0], 2);
    for (int a = 0; a <= 9; a++) begin
      rd_addr = 4'(a);
      cyc();
`ifdef PWM_BANK_READBACK_EN
      exp_rb = (a == 0) ? 16'd2 : (a == 8) ? 16'd9 : 16'd0;
`else
      exp_rb = 16'd0;
`endif
      $display("readback addr=%0d data=%0h", a, rd_data);
      check($sformatf("readback_%0d", a), longint'(rd_data), longint'(exp_rb));
    end

    for (int n = 0; n < 500; n++) begin
      wr_en = ($urandom_range(0, 9) < 3);
      wr_addr = 4'($urandom_range(0, 10));
      if (wr_addr == 4'd8) wr_data = W'($urandom_range(0, 12));
      else if ($urandom_range(0, 7) == 0) wr_data = 16'hFFFF;
      else if (wr_addr > 4'd8) wr_data = W'($urandom);
      else wr_data = W'($urandom_range(0, 14));
      rd_addr = 4'($urandom_range(0, 15));
      cyc();
      check_model("rand");
    end
    wr_en = 1'b0;
    $display("random phase done: %0d errors so far", n_err);

    write(4'd8, 16'd9);
    write(4'd0, 16'd3);
    wait_tick();
    wait_tick();
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd5; rd_addr = 4'd0;
    cyc();
    rst = 1'b1; wr_en = 1'b0;
    check("midrst_pwm", longint'(pwm_out), 0);
    check("midrst_tick", longint'(period_tick), 0);
    check("midrst_rd", longint'(rd_data), 0);
    cyc();
    check("midrst_duty_sh", longint'(rd_data), 0);
    rd_addr = 4'd8;
    cyc();
`ifdef PWM_BANK_READBACK_EN
    check("midrst_period_sh", longint'(rd_data), 16'hFFFF);
`else
    check("midrst_period_sh", longint'(rd_data), 0);
`endif
    any_hi = 1'b0; n_tick = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (pwm_out != '0) any_hi = 1'b1;
      if (period_tick) n_tick++;
    end
    check("midrst_pwm_stays_low", longint'(any_hi), 0);
    check("midrst_no_tick", n_tick, 0);
    check_model("midrst");
    $display("mid-period reset: pwm=%0h ticks=%0d", pwm_out, n_tick);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
